// File: rtl/atomic_unit.sv
// ---------------------------------------------------------------------------
// atomic_unit
// Executes RISC-V style LR/SC and AMO instructions for the execute stage.
// The unit holds a single reservation (granule address, valid, timeout
// counter) and runs one atomic operation at a time through a small FSM.
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous active-high reset
//   stall               freezes all state except snoop invalidation
//   enable_i            atomic instruction present in execute
//   op_i                0 LR, 1 SC, 2 SWAP, 3 ADD, 4 XOR, 5 AND, 6 OR,
//                       7 MIN, 8 MAX, 9 MINU, 10 MAXU, 11-15 illegal
//   addr_i              rs1 address
//   rs2_data_i          rs2 operand
//   mem_data_i          read data, valid the cycle after mem_read_enable_o
//   snoop_write_i       another agent writes memory this cycle
//   snoop_addr_i        address of that write
//   hold_o              stall upstream pipeline
//   mem_read_enable_o   memory read strobe
//   mem_write_enable_o  memory write strobe
//   mem_addr_o          memory address, always equal to addr_i
//   mem_data_o          memory write data
//   write_enable_o      rd writeback strobe
//   result_o            rd value
//   illegal_o           illegal op_i flag
// ---------------------------------------------------------------------------
module atomic_unit #(
    parameter int XLEN         = 32,
    parameter int GRAN_LOG2    = 2,
    parameter int RESV_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            enable_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic            snoop_write_i,
    input  logic [XLEN-1:0] snoop_addr_i,
    output logic            hold_o,
    output logic            mem_read_enable_o,
    output logic            mem_write_enable_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_data_o,
    output logic            write_enable_o,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o
);

    localparam int GW = XLEN - GRAN_LOG2;
    localparam int CW = (RESV_TIMEOUT > 1) ? $clog2(RESV_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(RESV_TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam bit            TIMEOUT_EN = (RESV_TIMEOUT != 0);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_READ     = 3'd1;
    localparam logic [2:0] S_WRITE    = 3'd2;
    localparam logic [2:0] S_SC_WRITE = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [3:0] OP_LR   = 4'd0;
    localparam logic [3:0] OP_SC   = 4'd1;
    localparam logic [3:0] OP_SWAP = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_MIN  = 4'd7;
    localparam logic [3:0] OP_MAX  = 4'd8;
    localparam logic [3:0] OP_MINU = 4'd9;
    localparam logic [3:0] OP_MAXU = 4'd10;

    logic [2:0]      state_q, state_d;
    logic [3:0]      opCode_q, opCode_d;
    logic [XLEN-1:0] loaded_q, loaded_d;
    logic            scOk_q, scOk_d;
    logic            resvValid_q, resvValid_d;
    logic [GW-1:0]   resvGranule_q, resvGranule_d;
    logic [CW-1:0]   resvCnt_q, resvCnt_d;

    logic [GW-1:0]   addrGranule;
    logic [GW-1:0]   snoopGranule;
    logic            opLegal;
    logic            snoopHitsAddr;
    logic            snoopHitsResv;
    logic            resvHitsAddr;
    logic [XLEN-1:0] amoResult;
    logic            unusedSnoopLow;

    assign addrGranule   = addr_i[XLEN-1:GRAN_LOG2];
    assign snoopGranule  = snoop_addr_i[XLEN-1:GRAN_LOG2];
    assign opLegal       = (op_i <= OP_MAXU);
    assign snoopHitsAddr = snoop_write_i && (snoopGranule == addrGranule);
    assign snoopHitsResv = snoop_write_i && resvValid_q && (snoopGranule == resvGranule_q);
    assign resvHitsAddr  = resvValid_q && (addrGranule == resvGranule_q);
    assign mem_addr_o    = addr_i;

    // Offset bits inside a granule never affect a reservation match.
    assign unusedSnoopLow = ^snoop_addr_i[GRAN_LOG2-1:0];

    // AMO datapath: combines the loaded word with rs2 for the write-back to memory.
    always_comb begin
        amoResult = rs2_data_i;
        case (opCode_q)
            OP_SWAP: amoResult = rs2_data_i;
            OP_ADD:  amoResult = loaded_q + rs2_data_i;
            OP_XOR:  amoResult = loaded_q ^ rs2_data_i;
            OP_AND:  amoResult = loaded_q & rs2_data_i;
            OP_OR:   amoResult = loaded_q | rs2_data_i;
            OP_MIN:  amoResult = ($signed(loaded_q) < $signed(rs2_data_i)) ? loaded_q : rs2_data_i;
            OP_MAX:  amoResult = ($signed(loaded_q) > $signed(rs2_data_i)) ? loaded_q : rs2_data_i;
            OP_MINU: amoResult = (loaded_q < rs2_data_i) ? loaded_q : rs2_data_i;
            OP_MAXU: amoResult = (loaded_q > rs2_data_i) ? loaded_q : rs2_data_i;
            default: amoResult = rs2_data_i;
        endcase
    end

    // Next-state logic. The FSM and data registers only move when not stalled;
    // the reservation is the exception because snoops must always invalidate it.
    always_comb begin
        state_d       = state_q;
        opCode_d      = opCode_q;
        loaded_d      = loaded_q;
        scOk_d        = scOk_q;
        resvValid_d   = resvValid_q;
        resvGranule_d = resvGranule_q;
        resvCnt_d     = resvCnt_q;

        if (!stall) begin
            case (state_q)
                S_IDLE: begin
                    if (enable_i && opLegal) begin
                        opCode_d = op_i;
                        if (op_i == OP_SC) begin
                            scOk_d  = resvHitsAddr && !snoopHitsAddr;
                            state_d = S_SC_WRITE;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
                S_READ: begin
                    loaded_d = mem_data_i;
                    state_d  = (opCode_q == OP_LR) ? S_DONE : S_WRITE;
                end
                S_WRITE:    state_d = S_DONE;
                S_SC_WRITE: state_d = S_DONE;
                S_DONE:     state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase

            // Expiry: the reservation dies on the cycle its counter would hit zero.
            if (TIMEOUT_EN && resvValid_q) begin
                if (resvCnt_q <= CNT_ONE) begin
                    resvValid_d = 1'b0;
                    resvCnt_d   = '0;
                end else begin
                    resvCnt_d = resvCnt_q - CNT_ONE;
                end
            end
            if (state_q == S_WRITE && resvHitsAddr) begin
                resvValid_d = 1'b0;
            end
            if (state_q == S_SC_WRITE) begin
                resvValid_d = 1'b0;
            end
        end

        if (snoopHitsResv) begin
            resvValid_d = 1'b0;
        end

        // A completing LR replaces the reservation, unless its own granule is
        // being written by someone else in this very cycle.
        if (!stall && state_q == S_READ && opCode_q == OP_LR) begin
            resvGranule_d = addrGranule;
            resvCnt_d     = CNT_RELOAD;
            resvValid_d   = !snoopHitsAddr;
        end
    end

    // State registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            opCode_q      <= OP_LR;
            loaded_q      <= '0;
            scOk_q        <= 1'b0;
            resvValid_q   <= 1'b0;
            resvGranule_q <= '0;
            resvCnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            opCode_q      <= opCode_d;
            loaded_q      <= loaded_d;
            scOk_q        <= scOk_d;
            resvValid_q   <= resvValid_d;
            resvGranule_q <= resvGranule_d;
            resvCnt_q     <= resvCnt_d;
        end
    end

    // Output decode: every strobe is zero unless the current state drives it.
    always_comb begin
        hold_o             = 1'b0;
        mem_read_enable_o  = 1'b0;
        mem_write_enable_o = 1'b0;
        mem_data_o         = '0;
        write_enable_o     = 1'b0;
        result_o           = '0;
        illegal_o          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    if (opLegal) begin
                        hold_o            = 1'b1;
                        mem_read_enable_o = (op_i != OP_SC);
                    end else begin
                        illegal_o = 1'b1;
                    end
                end
            end
            S_READ: hold_o = 1'b1;
            S_WRITE: begin
                hold_o             = 1'b1;
                mem_write_enable_o = 1'b1;
                mem_data_o         = amoResult;
            end
            S_SC_WRITE: begin
                hold_o             = 1'b1;
                mem_write_enable_o = scOk_q;
                mem_data_o         = rs2_data_i;
            end
            S_DONE: begin
                write_enable_o = 1'b1;
                result_o       = (opCode_q == OP_SC) ? {{(XLEN-1){1'b0}}, ~scOk_q} : loaded_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_atomic_unit.sv
// ---------------------------------------------------------------------------
// tb_atomic_unit
// Two instances share one set of inputs: dutA uses 4-byte granules and the
// default 64-cycle timeout, dutB uses 8-byte granules and a 4-cycle timeout,
// so granule and expiry behaviour can be contrasted in the same sequence.
// ---------------------------------------------------------------------------
module tb_atomic_unit;

   localparam logic [3:0] OP_LR   = 4'd0;
   localparam logic [3:0] OP_SC   = 4'd1;
   localparam logic [3:0] OP_SWAP = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_MIN  = 4'd7;
   localparam logic [3:0] OP_MAX  = 4'd8;
   localparam logic [3:0] OP_MINU = 4'd9;
   localparam logic [3:0] OP_MAXU = 4'd10;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] mem;
      logic [31:0] rs2;
      logic [31:0] expWrite;
   } amoVec_t;

   logic        clk = 1'b0;
   logic        reset, stall, enable, snoopWrite;
   logic [3:0]  op;
   logic [31:0] addr, rs2, memData, snoopAddr;

   logic        holdA, memReA, memWeA, weA, illegalA;
   logic [31:0] memAddrA, memDataA, resultA;
   logic        holdB, memReB, memWeB, weB, illegalB;
   logic [31:0] memAddrB, memDataB, resultB;

   int checks = 0;
   int errors = 0;
   amoVec_t vecs[10];

   always #5 clk = ~clk;

   atomic_unit #(.XLEN(32), .GRAN_LOG2(2), .RESV_TIMEOUT(64)) dutA (
      .clk(clk), .reset(reset), .stall(stall), .enable_i(enable), .op_i(op),
      .addr_i(addr), .rs2_data_i(rs2), .mem_data_i(memData),
      .snoop_write_i(snoopWrite), .snoop_addr_i(snoopAddr),
      .hold_o(holdA), .mem_read_enable_o(memReA), .mem_write_enable_o(memWeA),
      .mem_addr_o(memAddrA), .mem_data_o(memDataA), .write_enable_o(weA),
      .result_o(resultA), .illegal_o(illegalA)
   );

   atomic_unit #(.XLEN(32), .GRAN_LOG2(3), .RESV_TIMEOUT(4)) dutB (
      .clk(clk), .reset(reset), .stall(stall), .enable_i(enable), .op_i(op),
      .addr_i(addr), .rs2_data_i(rs2), .mem_data_i(memData),
      .snoop_write_i(snoopWrite), .snoop_addr_i(snoopAddr),
      .hold_o(holdB), .mem_read_enable_o(memReB), .mem_write_enable_o(memWeB),
      .mem_addr_o(memAddrB), .mem_data_o(memDataB), .write_enable_o(weB),
      .result_o(resultB), .illegal_o(illegalB)
   );

   // Compare one word and log any difference.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Single-bit flavour of checkOutput.
   task automatic checkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Step to just after the next rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Present a new instruction and let combinational outputs settle.
   task automatic applyStimulus(input logic en, input logic [3:0] o, input logic [31:0] a, input logic [31:0] d);
      enable = en;
      op     = o;
      addr   = a;
      rs2    = d;
      #1;
   endtask

   // Burn n cycles with no instruction, optionally stalled.
   task automatic idleCycles(input int n, input logic st);
      enable = 1'b0;
      stall  = st;
      repeat (n) nextCycle();
      stall = 1'b0;
   endtask

   // LR on both instances: read strobe, capture, writeback on the third cycle.
   task automatic doLr(input string tag, input logic [31:0] a, input logic [31:0] m);
      applyStimulus(1'b1, OP_LR, a, 32'h0);
      checkBit({tag, " lr read strobe"}, memReA, 1'b1);
      nextCycle();
      memData = m;
      #1;
      checkBit({tag, " lr hold in read"}, holdA, 1'b1);
      nextCycle();
      checkBit({tag, " lr writeback"}, weA, 1'b1);
      checkOutput({tag, " lr result A"}, resultA, m);
      checkOutput({tag, " lr result B"}, resultB, m);
      nextCycle();
      enable = 1'b0;
      #1;
   endtask

   // SC on both instances with per-instance expected success.
   task automatic doSc(input string tag, input logic [31:0] a, input logic [31:0] d, input logic okA, input logic okB);
      applyStimulus(1'b1, OP_SC, a, d);
      checkBit({tag, " sc hold"}, holdA, 1'b1);
      checkBit({tag, " sc no read"}, memReA, 1'b0);
      nextCycle();
      checkBit({tag, " sc write A"}, memWeA, okA);
      checkBit({tag, " sc write B"}, memWeB, okB);
      checkOutput({tag, " sc data"}, memDataA, d);
      nextCycle();
      checkBit({tag, " sc writeback"}, weA, 1'b1);
      checkOutput({tag, " sc result A"}, resultA, okA ? 32'd0 : 32'd1);
      checkOutput({tag, " sc result B"}, resultB, okB ? 32'd0 : 32'd1);
      nextCycle();
      enable = 1'b0;
      #1;
   endtask

   // Full AMO on dutA: read, write of the combined value, old value to rd.
   task automatic doAmo(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] m, input logic [31:0] d, input logic [31:0] expW);
      applyStimulus(1'b1, o, a, d);
      checkBit({tag, " read strobe"}, memReA, 1'b1);
      nextCycle();
      memData = m;
      #1;
      checkBit({tag, " no write in read"}, memWeA, 1'b0);
      nextCycle();
      checkBit({tag, " write strobe"}, memWeA, 1'b1);
      checkOutput({tag, " write data"}, memDataA, expW);
      nextCycle();
      checkBit({tag, " writeback"}, weA, 1'b1);
      checkBit({tag, " hold released"}, holdA, 1'b0);
      checkOutput({tag, " result"}, resultA, m);
      nextCycle();
      enable = 1'b0;
      #1;
   endtask

   // Main sequence: reset, illegal ops, AMO table, reservation corner cases, reset mid-write.
   initial begin
      vecs[0] = '{OP_SWAP, 32'h1234_5678, 32'hCAFE_BABE, 32'hCAFE_BABE};
      vecs[1] = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
      vecs[2] = '{OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
      vecs[3] = '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
      vecs[4] = '{OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
      vecs[5] = '{OP_MIN,  32'h8000_0000, 32'h0000_0001, 32'h8000_0000};
      vecs[6] = '{OP_MINU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
      vecs[7] = '{OP_MAX,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
      vecs[8] = '{OP_MAXU, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000};
      vecs[9] = '{OP_MAX,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

      reset = 1'b1; stall = 1'b0; enable = 1'b0; snoopWrite = 1'b0;
      op = OP_LR; addr = 32'h0; rs2 = 32'h0; memData = 32'h0; snoopAddr = 32'h0;
      #2;
      checkBit("reset hold", holdA, 1'b0);
      checkBit("reset read", memReA, 1'b0);
      checkBit("reset write", memWeA, 1'b0);
      checkBit("reset writeback", weA, 1'b0);
      checkOutput("reset result", resultA, 32'h0);
      applyStimulus(1'b1, OP_LR, 32'h40, 32'h0);
      checkBit("reset lr read request", memReA, 1'b1);
      checkBit("reset lr hold request", holdA, 1'b1);
      enable = 1'b0;
      nextCycle();
      reset = 1'b0;
      nextCycle();

      applyStimulus(1'b1, 4'd12, 32'h700, 32'h0);
      checkBit("illegal12 flag", illegalA, 1'b1);
      checkBit("illegal12 hold", holdA, 1'b0);
      checkBit("illegal12 read", memReA, 1'b0);
      checkOutput("mem addr passthrough", memAddrA, 32'h700);
      nextCycle();
      enable = 1'b0;
      #1;
      checkBit("illegal flag drops", illegalA, 1'b0);
      applyStimulus(1'b1, 4'd11, 32'h700, 32'h0);
      checkBit("illegal11 flag", illegalA, 1'b1);
      checkBit("illegal11 read", memReA, 1'b0);
      nextCycle();
      enable = 1'b0;
      #1;

      for (int i = 0; i < 10; i++) begin
         doAmo($sformatf("amo[%0d]", i), vecs[i].op, 32'h200, vecs[i].mem, vecs[i].rs2, vecs[i].expWrite);
      end

      doLr("granule", 32'h100, 32'hDEAD_BEEF);
      doSc("granule", 32'h104, 32'h55, 1'b0, 1'b1);

      doLr("amo clear", 32'h600, 32'h1);
      doAmo("amo clear swap", OP_SWAP, 32'h600, 32'h1, 32'h2, 32'h2);
      doSc("amo clear", 32'h600, 32'h3, 1'b0, 1'b0);

      doLr("amo other", 32'h600, 32'h1);
      doAmo("amo other swap", OP_SWAP, 32'h608, 32'h1, 32'h2, 32'h2);
      doSc("amo other", 32'h600, 32'h3, 1'b1, 1'b0);

      doLr("snoop", 32'h300, 32'h7);
      enable = 1'b0; stall = 1'b1; snoopWrite = 1'b1; snoopAddr = 32'h300;
      nextCycle();
      snoopWrite = 1'b0; stall = 1'b0;
      doSc("snoop", 32'h300, 32'h9, 1'b0, 1'b0);

      doLr("no snoop", 32'h300, 32'h7);
      doSc("no snoop", 32'h300, 32'h9, 1'b1, 1'b1);

      doLr("stall freeze", 32'h400, 32'h5);
      idleCycles(4, 1'b1);
      idleCycles(2, 1'b0);
      doSc("stall freeze", 32'h400, 32'h6, 1'b1, 1'b1);

      doLr("timeout5", 32'h400, 32'h5);
      idleCycles(5, 1'b0);
      doSc("timeout5", 32'h400, 32'h6, 1'b1, 1'b0);

      doLr("timeout2", 32'h400, 32'h5);
      idleCycles(2, 1'b0);
      doSc("timeout2", 32'h400, 32'h6, 1'b1, 1'b1);

      applyStimulus(1'b1, OP_ADD, 32'h500, 32'd5);
      nextCycle();
      memData = 32'd10;
      nextCycle();
      checkBit("midreset write before", memWeA, 1'b1);
      checkOutput("midreset data before", memDataA, 32'd15);
      #2;
      reset = 1'b1;
      #1;
      checkBit("midreset write drops", memWeA, 1'b0);
      checkOutput("midreset data drops", memDataA, 32'h0);
      checkBit("midreset writeback", weA, 1'b0);
      enable = 1'b0;
      #1;
      checkBit("midreset hold", holdA, 1'b0);
      nextCycle();
      reset = 1'b0;
      nextCycle();
      checkBit("postreset write", memWeA, 1'b0);
      checkBit("postreset writeback", weA, 1'b0);
      doLr("postreset", 32'h800, 32'hA5A5_A5A5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/atomic_unit.md
ATOMIC_UNIT -- requirements
Module: atomic_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width (32 or 64).
REQ-002 SHALL have parameter GRAN_LOG2, default 2, log2 of reservation granule size in bytes.
REQ-003 SHALL have parameter RESV_TIMEOUT, default 64, cycles until an unused reservation expires; 0 = never.
REQ-004 SHALL have ports, one per line:
  clk  in  1  clock, rising edge.
  reset  in  1  asynchronous, active-high reset.
  stall  in  1  pipeline stall; freezes all state except snoop invalidation.
  enable_i  in  1  atomic instruction present in execute.
  op_i  in  4  0 LR, 1 SC, 2 SWAP, 3 ADD, 4 XOR, 5 AND, 6 OR, 7 MIN, 8 MAX, 9 MINU, 10 MAXU; 11-15 illegal.
  addr_i  in  XLEN  rs1 address.
  rs2_data_i  in  XLEN  rs2 operand.
  mem_data_i  in  XLEN  read data, valid the cycle after mem_read_enable_o.
  snoop_write_i  in  1  another agent/store writes memory this cycle.
  snoop_addr_i  in  XLEN  address of that write.
  hold_o  out  1  stall upstream pipeline.
  mem_read_enable_o  out  1  memory read strobe.
  mem_write_enable_o  out  1  memory write strobe.
  mem_addr_o  out  XLEN  memory address (= addr_i).
  mem_data_o  out  XLEN  memory write data.
  write_enable_o  out  1  rd writeback strobe.
  result_o  out  XLEN  rd value.
  illegal_o  out  1  illegal op_i flag.

Function
REQ-005 SHALL implement FSM states IDLE, READ, WRITE, SC_WRITE, DONE; state and data registers advance only when stall=0.
REQ-006 IDLE, enable_i=1, op LR or AMO: mem_read_enable_o=1, hold_o=1, next READ.
REQ-007 IDLE, enable_i=1, op SC: hold_o=1, next SC_WRITE; sc_ok registered = resv_valid and granule(addr_i)==resv_granule and no matching snoop this cycle.
REQ-008 IDLE, enable_i=1, illegal op: illegal_o=1 combinationally, hold_o=0, stay IDLE, no memory access.
REQ-009 READ: hold_o=1, capture mem_data_i into loaded; LR -> DONE and set reservation; AMO -> WRITE.
REQ-010 WRITE: mem_write_enable_o=1, mem_data_o=op(loaded, rs2_data_i), hold_o=1, next DONE.
REQ-011 AMO ops: SWAP=rs2; ADD modulo 2^XLEN; XOR/AND/OR bitwise; MIN/MAX signed XLEN compare; MINU/MAXU unsigned.
REQ-012 SC_WRITE: mem_write_enable_o=sc_ok, mem_data_o=rs2_data_i, hold_o=1, reservation cleared unconditionally, next DONE.
REQ-013 DONE: write_enable_o=1, hold_o=0, next IDLE; result_o=loaded for LR/AMO, 0 on SC success, 1 on SC failure.
REQ-014 Latency: LR 3 cycles, SC 3, AMO 4 (excluding stall cycles); one operation in flight.
REQ-015 Granule = address bits [XLEN-1:GRAN_LOG2]; reservation holds resv_valid, resv_granule, timeout counter.
REQ-016 Reservation cleared by: SC, snoop_write_i with matching granule, AMO write to matching granule, counter reaching 0, reset.
REQ-017 Snoop invalidation SHALL be applied even when stall=1.
REQ-018 Matching snoop in same cycle as LR in READ: reservation SHALL NOT be set.
REQ-019 New LR replaces any existing reservation and reloads counter to RESV_TIMEOUT.
REQ-020 Counter decrements once per non-stall cycle while valid; RESV_TIMEOUT=0 disables expiry.
REQ-021 Outputs not named active in a state SHALL be 0; mem_addr_o SHALL equal addr_i at all times.

Reset
REQ-022 reset=1 SHALL immediately force IDLE, resv_valid=0, counter=0, loaded=0, result_o=0, sc_ok=0; all strobes and hold_o=0 unless enable_i requests per REQ-006/007.
REQ-023 Reset mid-operation SHALL abandon the operation with no further memory write.

Verification
REQ-024 LR 0x100 (mem=0xDEAD_BEEF), then SC 0x104 (same granule if GRAN_LOG2>=3, else different) -> result_o 0 and write when match, 1 and no write otherwise.
REQ-025 AMOADD 0x200, mem=0xFFFF_FFFF, rs2=2 -> mem_data_o=0x0000_0001, result_o=0xFFFF_FFFF, 4 cycles.
REQ-026 AMOMIN vs AMOMINU, mem=0x8000_0000, rs2=1 -> writes 0x8000_0000 and 0x0000_0001 respectively.
REQ-027 LR 0x300, snoop_write_i to 0x300 during stall, then SC 0x300 -> result_o=1, mem_write_enable_o=0.
REQ-028 RESV_TIMEOUT=4: LR then 5 idle cycles then SC -> fails; SC after 2 cycles -> succeeds.
REQ-029 op_i=12 -> illegal_o=1 one cycle, hold_o=0; reset asserted in WRITE -> strobes drop same cycle, FSM IDLE.
